cae_row_feeder: RTL and testbench
=================================

Name: cae_row_feeder

Overview:
Producer-side front end for the CAE datapath. It accepts image lines over a valid/ready stream, keeps a 3-line sliding window, and drives the three data-row and three weight-row inputs plus the enable of the convolution core. It waits for the core's conv_done before sliding the window, so one frame of IMG_ROWS lines yields IMG_ROWS-2 convolution passes, then it signals frame completion.

Parameters:
DATA_WIDTH, 8, width of one pixel/weight element
INPUT_SIZE, 15, elements per line and per row output
IMG_ROWS, 15, lines per frame (minimum 3)
CNT_WIDTH, 4, width of line/window counters (must hold IMG_ROWS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
start  in  1  one-cycle frame start, honoured only in IDLE
w_valid  in  1  weight set valid, honoured only in IDLE
w_data  in  3*INPUT_SIZE*DATA_WIDTH  weight rows 1..3, row1 in LSBs
line_valid  in  1  input line valid
line_ready  out  1  feeder accepts line this cycle
line_data  in  INPUT_SIZE*DATA_WIDTH  one image line
conv_done  in  1  core finished current window
enable  out  1  core enable
data_row1_out / data_row2_out / data_row3_out  out  INPUT_SIZE*DATA_WIDTH each  window lines, oldest to newest
weight_row1_out / weight_row2_out / weight_row3_out  out  INPUT_SIZE*DATA_WIDTH each  latched weights
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after last window

Behaviour:
- Reset (rst=0, async): state IDLE; all line, weight and window registers 0; counters 0; enable, line_ready, busy, frame_done 0.
- Window registers: L0, L1, L2 drive data_row1/2/3_out. A line load performs L0<=L1, L1<=L2, L2<=line_data.
- Weight registers: load from w_data when w_valid=1 in IDLE. They hold their value across frames. w_valid outside IDLE is ignored.
- FSM:
  - IDLE: on start=1, go to FILL and clear line_cnt and win_cnt. If start and w_valid arrive in the same cycle, the weights load and the frame starts.
  - FILL: line_ready=1. Each handshake (line_valid & line_ready) loads one line and increments line_cnt. On the 3rd line go to RUN.
  - RUN: enable=1 and held. Window registers are frozen. When conv_done=1 is sampled, enable drops the next cycle, win_cnt increments, and the next state is chosen:
    - win_cnt (new value) == IMG_ROWS-2: go to DONE.
    - otherwise: go to SLIDE.
  - SLIDE: enable=0, line_ready=1. A handshake loads one line and returns to RUN on the next cycle. Waits indefinitely for line_valid.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Enable gap: enable is 0 for at least one cycle between consecutive windows.
- Latency:
  - First enable rises the cycle after the 3rd line handshake.
  - conv_done to next enable rise is 2 cycles minimum (SLIDE with line_valid already high).
- line_ready is registered-state-derived only. It has no combinational path from line_valid.
- conv_done outside RUN is ignored.
- start outside IDLE is ignored.
- Reset mid-frame: immediate return to IDLE and all outputs to reset values. Weights are also cleared.
- Lines offered while line_ready=0 are not consumed, and the producer must hold them.

Test Plan:
- Reset, then w_valid with row elements 1/2/3, then start, then 15 lines with line k elements = k. Core model asserts conv_done 5 cycles after each enable rise. Required: 13 enable pulses; window n shows rows (n, n+1, n+2); frame_done pulses once after the 13th conv_done; busy falls with IDLE.
- FILL with line_valid toggling every other cycle. Required: exactly 3 lines consumed, no duplicates, and enable rises the cycle after the 3rd handshake.
- line_valid held low in SLIDE for 20 cycles. Required: enable stays 0, windows unchanged, and resume loads the correct next line.
- start and w_valid pulsed during RUN. Required: no state change and weights unchanged. conv_done pulsed in IDLE produces no effect.
- rst asserted during RUN of window 7. Required: all outputs 0 immediately; a new start restarts at line 0 and requires weights to be reloaded.
- IMG_ROWS=3 build. Required: exactly one window after the 3 lines, then frame_done with no SLIDE state visited.

Source files
------------

// File: rtl/cae_row_feeder.sv
// CAE row feeder: buffers a 3-line sliding window from a line stream and drives the
// convolution core's data/weight rows and enable, one core pass per window position.

module cae_row_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (ld) q <= d;
    end
endmodule

module cae_row_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int INPUT_SIZE = 15,
    parameter int IMG_ROWS   = 15,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 w_valid,
    input  logic [3*INPUT_SIZE*DATA_WIDTH-1:0]   w_data,
    input  logic                                 line_valid,
    output logic                                 line_ready,
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0]     line_data,
    input  logic                                 conv_done,
    output logic                                 enable,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0]     data_row1_out,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0]     data_row2_out,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0]     data_row3_out,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0]     weight_row1_out,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0]     weight_row2_out,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0]     weight_row3_out,
    output logic                                 busy,
    output logic                                 frame_done
);
    localparam int LW = INPUT_SIZE * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_WIN  = CNT_WIDTH'(IMG_ROWS - 2);
    localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(2);

    typedef enum logic [2:0] {IDLE, FILL, RUN, SLIDE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [2:0][LW-1:0]     win;
    logic [2:0][LW-1:0]     wgt;
    logic [CNT_WIDTH-1:0]   line_cnt, win_cnt, win_cnt_inc;
    logic                   line_hs, w_load, frame_go, win_end;

    assign win_cnt_inc = win_cnt + 1'b1;

    // All outputs decode from the state register only, so line_ready never
    // depends combinationally on line_valid.
    always_comb begin
        state_nxt  = state;
        line_ready = 1'b0;
        enable     = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        line_hs    = 1'b0;
        w_load     = 1'b0;
        frame_go   = 1'b0;
        win_end    = 1'b0;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                w_load = w_valid;
                if (start) begin
                    frame_go  = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                line_ready = 1'b1;
                line_hs    = line_valid;
                if (line_valid && line_cnt == FILL_LAST) state_nxt = RUN;
            end
            RUN: begin
                enable = 1'b1;
                if (conv_done) begin
                    win_end   = 1'b1;
                    state_nxt = (win_cnt_inc == LAST_WIN) ? DONE : SLIDE;
                end
            end
            SLIDE: begin
                line_ready = 1'b1;
                line_hs    = line_valid;
                if (line_valid) state_nxt = RUN;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            line_cnt <= '0;
            win_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (frame_go)     line_cnt <= '0;
            else if (line_hs) line_cnt <= line_cnt + 1'b1;
            if (frame_go)     win_cnt  <= '0;
            else if (win_end) win_cnt  <= win_cnt_inc;
        end
    end

    // Slot 2 takes the incoming line; lower slots take the one above (oldest drops out).
    for (genvar k = 0; k < 3; k++) begin : g_row
        if (k == 2) begin : g_new
            cae_row_slot #(.W(LW)) u_win (
                .clk(clk), .rst(rst), .ld(line_hs), .d(line_data), .q(win[k])
            );
        end else begin : g_old
            cae_row_slot #(.W(LW)) u_win (
                .clk(clk), .rst(rst), .ld(line_hs), .d(win[k+1]), .q(win[k])
            );
        end
        cae_row_slot #(.W(LW)) u_wgt (
            .clk(clk), .rst(rst), .ld(w_load), .d(w_data[k*LW +: LW]), .q(wgt[k])
        );
    end

    assign data_row1_out   = win[0];
    assign data_row2_out   = win[1];
    assign data_row3_out   = win[2];
    assign weight_row1_out = wgt[0];
    assign weight_row2_out = wgt[1];
    assign weight_row3_out = wgt[2];

endmodule

// File: tb/tb_cae_row_feeder.sv
// Randomized scoreboard bench for cae_row_feeder: expected windows are queued per frame,
// a monitor checks each enable rise and frame_done; a second instance covers IMG_ROWS=3.

module tb_cae_row_feeder;
    localparam int DW = 8;
    localparam int IS = 15;
    localparam int IR = 15;
    localparam int CW = 4;
    localparam int LW = DW * IS;

    typedef logic [LW-1:0] line_t;
    typedef struct {
        line_t r1, r2, r3, w1, w2, w3;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, w_valid = 1'b0, line_valid = 1'b0;
    logic [3*LW-1:0] w_data = '0;
    line_t line_data = '0;
    logic cd_core = 1'b0, cd_man = 1'b0;
    logic conv_done;
    logic line_ready, enable, busy, frame_done;
    line_t data_row1_out, data_row2_out, data_row3_out;
    line_t weight_row1_out, weight_row2_out, weight_row3_out;

    logic st3 = 1'b0, wv3 = 1'b0, lv3 = 1'b0, cd3 = 1'b0;
    logic [3*LW-1:0] wd3 = '0;
    line_t ld3 = '0;
    logic lr3, en3, busy3, fd3;
    line_t r1_3, r2_3, r3_3, w1_3, w2_3, w3_3;

    assign conv_done = cd_core | cd_man;

    always #5 clk = ~clk;

    cae_row_feeder #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .IMG_ROWS(IR), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_data(w_data),
        .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
        .conv_done(conv_done), .enable(enable),
        .data_row1_out(data_row1_out), .data_row2_out(data_row2_out), .data_row3_out(data_row3_out),
        .weight_row1_out(weight_row1_out), .weight_row2_out(weight_row2_out),
        .weight_row3_out(weight_row3_out), .busy(busy), .frame_done(frame_done)
    );

    cae_row_feeder #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .IMG_ROWS(3), .CNT_WIDTH(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(st3), .w_valid(wv3), .w_data(wd3),
        .line_valid(lv3), .line_ready(lr3), .line_data(ld3),
        .conv_done(cd3), .enable(en3),
        .data_row1_out(r1_3), .data_row2_out(r2_3), .data_row3_out(r3_3),
        .weight_row1_out(w1_3), .weight_row2_out(w2_3), .weight_row3_out(w3_3),
        .busy(busy3), .frame_done(fd3)
    );

    int n_vec = 0;
    int n_bad = 0;
    win_t win_q[$];
    int   done_q[$];
    line_t lines[IR];
    line_t wmod[3];
    int frame_wins = 0;

    task automatic checkw(input string nm, input line_t act, input line_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t v;
        for (int j = 0; j < IS; j++) v[j*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic line_t const_line(input int k);
        line_t v;
        for (int j = 0; j < IS; j++) v[j*DW +: DW] = DW'(k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core stand-in: conv_done pulses 5 cycles after each enable rise.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            step();
            if (rst && enable && !prev) begin
                repeat (4) @(posedge clk);
                #1 cd_core = 1'b1;
                step();
                cd_core = 1'b0;
            end
            prev = enable;
        end
    end

    // Monitor: each enable rise must present the next queued window.
    initial begin
        logic en_prev, chk_busy;
        win_t e;
        en_prev  = 1'b0;
        chk_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_prev    = 1'b0;
                chk_busy   = 1'b0;
                frame_wins = 0;
            end else begin
                if (chk_busy) begin
                    check1("busy_after_done", busy, 1'b0);
                    chk_busy = 1'b0;
                end
                if (enable && !en_prev) begin
                    if (win_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_window: got enable rise expected none");
                    end else begin
                        e = win_q.pop_front();
                        checkw("win_row1", data_row1_out, e.r1);
                        checkw("win_row2", data_row2_out, e.r2);
                        checkw("win_row3", data_row3_out, e.r3);
                        checkw("win_wgt1", weight_row1_out, e.w1);
                        checkw("win_wgt2", weight_row2_out, e.w2);
                        checkw("win_wgt3", weight_row3_out, e.w3);
                        frame_wins++;
                    end
                end
                if (frame_done) begin
                    if (done_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_frame_done: got pulse expected none");
                    end else begin
                        checki("frame_windows", frame_wins, done_q.pop_front());
                    end
                    frame_wins = 0;
                    chk_busy   = 1'b1;
                end
                en_prev = enable;
            end
        end
    end

    task automatic start_frame(input logic ld, input logic [3*LW-1:0] wd);
        win_t e;
        w_data  = wd;
        w_valid = ld;
        start   = 1'b1;
        if (ld) begin
            wmod[0] = wd[LW-1:0];
            wmod[1] = wd[2*LW-1:LW];
            wmod[2] = wd[3*LW-1:2*LW];
        end
        for (int n = 0; n < IR - 2; n++) begin
            e.r1 = lines[n]; e.r2 = lines[n+1]; e.r3 = lines[n+2];
            e.w1 = wmod[0];  e.w2 = wmod[1];    e.w3 = wmod[2];
            win_q.push_back(e);
        end
        done_q.push_back(IR - 2);
        step();
        start   = 1'b0;
        w_valid = 1'b0;
    endtask

    task automatic push_line(input line_t d, input logic gap, output logic en_after);
        int n;
        n = 0;
        en_after   = 1'b0;
        line_data  = d;
        line_valid = 1'b1;
        while (!line_ready) begin
            step();
            n++;
            if (n > 3000) begin
                checki("line_accept_timeout", n, 0);
                line_valid = 1'b0;
                return;
            end
        end
        step();
        en_after   = enable;
        line_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_enable"}, enable, 1'b0);
        check1({tag, "_line_ready"}, line_ready, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_frame_done"}, frame_done, 1'b0);
        checkw({tag, "_row1"}, data_row1_out, '0);
        checkw({tag, "_row2"}, data_row2_out, '0);
        checkw({tag, "_row3"}, data_row3_out, '0);
        checkw({tag, "_wgt1"}, weight_row1_out, '0);
        checkw({tag, "_wgt2"}, weight_row2_out, '0);
        checkw({tag, "_wgt3"}, weight_row3_out, '0);
    endtask

    task automatic send_frame(input logic gap, input int stall_at, input int pulse_at, input int reset_at);
        logic en_a;
        int n;
        for (int i = 0; i < IR; i++) begin
            if (i == stall_at) begin
                n = 0;
                while (!line_ready && n < 100) begin step(); n++; end
                check1("slide_reached", line_ready, 1'b1);
                for (int c = 0; c < 20; c++) begin
                    step();
                    check1("stall_enable", enable, 1'b0);
                end
                checkw("stall_row1", data_row1_out, lines[i-3]);
                checkw("stall_row2", data_row2_out, lines[i-2]);
                checkw("stall_row3", data_row3_out, lines[i-1]);
                check1("stall_ready", line_ready, 1'b1);
            end
            push_line(lines[i], gap && (i < 3), en_a);
            if (i >= 2) check1("enable_after_line", en_a, 1'b1);
            else        check1("enable_during_fill", en_a, 1'b0);
            if (i == pulse_at) begin
                w_data  = {rand_line(), rand_line(), rand_line()};
                w_valid = 1'b1;
                start   = 1'b1;
                step();
                w_valid = 1'b0;
                start   = 1'b0;
                check1("run_pulse_enable", enable, 1'b1);
                check1("run_pulse_busy", busy, 1'b1);
            end
            if (i == reset_at) begin
                @(posedge clk);
                #3 rst = 1'b0;
                #1 check_reset_outputs("midframe_rst");
                win_q.delete();
                done_q.delete();
                for (int k = 0; k < 3; k++) wmod[k] = '0;
                line_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin step(); n++; end
        if (n >= 5000) checki("frame_timeout", n, 0);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t l3[3];
        logic [3*LW-1:0] wd3v;
        int n;
        for (int k = 0; k < 3; k++) wmod[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check1("reset_busy3", busy3, 1'b0);
        check1("reset_enable3", en3, 1'b0);
        rst = 1'b1;
        step();

        // conv_done in IDLE must not wake the feeder
        cd_man = 1'b1;
        step();
        cd_man = 1'b0;
        step();
        check1("idle_cd_busy", busy, 1'b0);
        check1("idle_cd_enable", enable, 1'b0);
        check1("idle_cd_ready", line_ready, 1'b0);

        // IMG_ROWS=3 instance: one window, then frame_done without SLIDE
        wd3v = {rand_line(), rand_line(), rand_line()};
        for (int k = 0; k < 3; k++) l3[k] = rand_line();
        wd3 = wd3v; wv3 = 1'b1; st3 = 1'b1;
        step();
        wv3 = 1'b0; st3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ld3 = l3[k];
            lv3 = 1'b1;
            n = 0;
            while (!lr3 && n < 50) begin step(); n++; end
            step();
            lv3 = 1'b0;
        end
        check1("r3_enable", en3, 1'b1);
        checkw("r3_row1", r1_3, l3[0]);
        checkw("r3_row2", r2_3, l3[1]);
        checkw("r3_row3", r3_3, l3[2]);
        checkw("r3_wgt1", w1_3, wd3v[LW-1:0]);
        checkw("r3_wgt3", w3_3, wd3v[3*LW-1:2*LW]);
        repeat (2) step();
        check1("r3_enable_held", en3, 1'b1);
        cd3 = 1'b1;
        step();
        cd3 = 1'b0;
        check1("r3_enable_drop", en3, 1'b0);
        check1("r3_frame_done", fd3, 1'b1);
        check1("r3_no_slide", lr3, 1'b0);
        check1("r3_busy_done", busy3, 1'b1);
        step();
        check1("r3_frame_done_once", fd3, 1'b0);
        check1("r3_busy_idle", busy3, 1'b0);

        // Frame A: known pattern, weights and start in the same cycle
        for (int i = 0; i < IR; i++) lines[i] = const_line(i + 1);
        start_frame(1'b1, {const_line(3), const_line(2), const_line(1)});
        send_frame(1'b0, -1, -1, -1);
        wait_idle();

        // Frame B: toggled FILL, stalled SLIDE, start/w_valid pulsed in RUN; weights held
        for (int i = 0; i < IR; i++) lines[i] = rand_line();
        start_frame(1'b0, '0);
        send_frame(1'b1, 6, 4, -1);
        wait_idle();

        // Frame C: new weights, reset during the 7th window
        for (int i = 0; i < IR; i++) lines[i] = rand_line();
        start_frame(1'b1, {rand_line(), rand_line(), rand_line()});
        send_frame(1'b0, -1, -1, 8);

        // Frame D: restart without reloading weights -> cleared weights
        for (int i = 0; i < IR; i++) lines[i] = rand_line();
        start_frame(1'b0, '0);
        send_frame(1'b0, -1, -1, -1);
        wait_idle();

        checki("leftover_windows", win_q.size(), 0);
        checki("leftover_frames", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
